// File: rtl/imem_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_program_loader
// Description : Streams a length/checksum-framed program image into CPU
//               instruction memory, then enables the CPU. The optional
//               readback pass is enabled with LOADER_VERIFY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_program_loader #(
    parameter int          ADDR_W    = 9,
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [63:0]       addr_ext,
    output logic              wen_ext,
    output logic              ren_ext,
    output logic [31:0]       wdata_ext,
    input  logic [31:0]       rdata_ext,
    output logic              cpu_enable,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_cnt
);

    localparam logic [3:0]  c_st_idle  = 4'd0;
    localparam logic [3:0]  c_st_hdr   = 4'd1;
    localparam logic [3:0]  c_st_data  = 4'd2;
    localparam logic [3:0]  c_st_write = 4'd3;
    localparam logic [3:0]  c_st_csum  = 4'd4;
    localparam logic [3:0]  c_st_done  = 4'd5;
    localparam logic [3:0]  c_st_err   = 4'd6;
`ifdef LOADER_VERIFY_EN
    localparam logic [3:0]  c_st_vrd   = 4'd7;
    localparam logic [3:0]  c_st_vcmp  = 4'd8;
`endif
    localparam logic [16:0] c_max_words = 17'(1) << ADDR_W;

    logic [3:0]      r_state;
    logic [3:0]      w_next;
    logic [1:0]      r_byte_cnt;
    logic [15:0]     r_n;
    logic [31:0]     r_word;
    logic [31:0]     r_xor;
    logic [ADDR_W:0] r_word_cnt;
    logic            r_done;
    logic            r_error;
    logic            r_cpu_en;

    logic            w_xfer;
    logic [15:0]     w_hdr_n;
    logic            w_hdr_bad;
    logic [31:0]     w_next_word;
    logic [ADDR_W:0] w_cnt_inc;
    logic            w_last;
    logic            w_restart;
    logic [ADDR_W:0] w_addr_idx;

`ifdef LOADER_VERIFY_EN
    logic [ADDR_W:0] r_vidx;
    logic [31:0]     r_vacc;
    logic [ADDR_W:0] w_vidx_inc;
    assign w_vidx_inc = r_vidx + (ADDR_W+1)'(1);
    assign w_addr_idx = (r_state == c_st_vrd) ? r_vidx : r_word_cnt;
`else
    logic            w_unused_rdata;
    assign w_unused_rdata = ^rdata_ext;
    assign w_addr_idx     = r_word_cnt;
`endif

    assign w_xfer      = in_valid & in_ready;
    assign w_hdr_n     = {in_data, r_n[7:0]};
    assign w_hdr_bad   = (w_hdr_n == 16'd0) || ({1'b0, w_hdr_n} > c_max_words);
    // Bytes arrive LSB first, so shifting in from the top leaves byte 0 in [7:0].
    assign w_next_word = {in_data, r_word[31:8]};
    assign w_cnt_inc   = r_word_cnt + (ADDR_W+1)'(1);
    assign w_last      = (16'(w_cnt_inc) == r_n);
    assign w_restart   = start && ((r_state == c_st_idle) || (r_state == c_st_done) ||
                                   (r_state == c_st_err));

    assign addr_ext   = BASE_ADDR + {{(64-ADDR_W-3){1'b0}}, w_addr_idx, 2'b00};
    assign wdata_ext  = r_word;
    assign word_cnt   = r_word_cnt;
    assign done       = r_done;
    assign error      = r_error;
    assign cpu_enable = r_cpu_en;

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        wen_ext  = 1'b0;
        ren_ext  = 1'b0;
        case (r_state)
            c_st_idle: if (start) w_next = c_st_hdr;
            c_st_hdr: begin
                in_ready = 1'b1;
                if (w_xfer && r_byte_cnt[0]) w_next = w_hdr_bad ? c_st_err : c_st_data;
            end
            c_st_data: begin
                in_ready = 1'b1;
                if (w_xfer && (r_byte_cnt == 2'd3)) w_next = c_st_write;
            end
            c_st_write: begin
                wen_ext = 1'b1;
                w_next  = w_last ? c_st_csum : c_st_data;
            end
            c_st_csum: begin
                in_ready = 1'b1;
                if (w_xfer && (r_byte_cnt == 2'd3)) begin
`ifdef LOADER_VERIFY_EN
                    w_next = (w_next_word == r_xor) ? c_st_vrd : c_st_err;
`else
                    w_next = (w_next_word == r_xor) ? c_st_done : c_st_err;
`endif
                end
            end
`ifdef LOADER_VERIFY_EN
            c_st_vrd: begin
                ren_ext = 1'b1;
                w_next  = c_st_vcmp;
            end
            c_st_vcmp: begin
                if (16'(w_vidx_inc) == r_n)
                    w_next = ((r_vacc ^ rdata_ext) == r_xor) ? c_st_done : c_st_err;
                else
                    w_next = c_st_vrd;
            end
`endif
            c_st_done: if (start) w_next = c_st_hdr;
            c_st_err:  if (start) w_next = c_st_hdr;
            default:   w_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_byte_cnt <= 2'd0;
            r_n        <= 16'd0;
            r_word     <= 32'd0;
            r_xor      <= 32'd0;
            r_word_cnt <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_cpu_en   <= 1'b0;
`ifdef LOADER_VERIFY_EN
            r_vidx     <= '0;
            r_vacc     <= 32'd0;
`endif
        end else begin
            r_state  <= w_next;
            r_done   <= (w_next == c_st_done);
            r_error  <= (w_next == c_st_err);
            r_cpu_en <= (w_next == c_st_done);
            if (w_restart) begin
                r_byte_cnt <= 2'd0;
                r_n        <= 16'd0;
                r_xor      <= 32'd0;
                r_word_cnt <= '0;
`ifdef LOADER_VERIFY_EN
                r_vidx     <= '0;
                r_vacc     <= 32'd0;
`endif
            end
            if (w_xfer) begin
                if (r_state == c_st_hdr) begin
                    if (r_byte_cnt[0]) begin
                        r_n[15:8]  <= in_data;
                        r_byte_cnt <= 2'd0;
                    end else begin
                        r_n[7:0]   <= in_data;
                        r_byte_cnt <= 2'd1;
                    end
                end else begin
                    r_word     <= w_next_word;
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                end
            end
            if (r_state == c_st_write) begin
                r_word_cnt <= w_cnt_inc;
                r_xor      <= r_xor ^ r_word;
            end
`ifdef LOADER_VERIFY_EN
            if (r_state == c_st_vcmp) begin
                r_vacc <= r_vacc ^ rdata_ext;
                r_vidx <= w_vidx_inc;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_program_loader
// Description : Scoreboard bench for imem_program_loader with a memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_program_loader;

    localparam int          ADDR_W = 9;
    localparam logic [63:0] BASE   = 64'h0;
`ifdef LOADER_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [7:0]      in_data = 8'h0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [63:0]     addr_ext;
    logic            wen_ext;
    logic            ren_ext;
    logic [31:0]     wdata_ext;
    logic [31:0]     rdata_ext = 32'h0;
    logic            cpu_enable;
    logic            done;
    logic            error;
    logic [ADDR_W:0] word_cnt;

    imem_program_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
        .wdata_ext(wdata_ext), .rdata_ext(rdata_ext), .cpu_enable(cpu_enable),
        .done(done), .error(error), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    // Instruction memory model; optionally corrupts word 1 on readback.
    logic [31:0] mem [0:1023];
    bit          corrupt = 1'b0;
    always @(posedge clk) begin
        if (wen_ext) mem[addr_ext[11:2]] <= wdata_ext;
        if (ren_ext) rdata_ext <= mem[addr_ext[11:2]] ^
                                  ((corrupt && addr_ext[11:2] == 10'd1) ? 32'h0000_0100 : 32'h0);
    end

    typedef struct packed { logic [63:0] addr; logic [31:0] data; } wr_t;
    typedef struct packed { logic d; logic e; logic [ADDR_W:0] cnt; } res_t;
    wr_t         exp_wr[$];
    res_t        exp_res[$];
    int          checks = 0;
    int          errors = 0;
    int          ren_cnt = 0;
    logic [63:0] last_wr_addr = 64'h0;
    logic [31:0] img[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event missing", name);
    endtask

    // Monitor: pops expected writes and outcomes as the DUT presents them.
    initial begin
        wr_t  w;
        res_t r;
        logic prev_fin = 1'b0;
        forever begin
            @(negedge clk);
            if (wen_ext) begin
                if (exp_wr.size() == 0) fail_now("unexpected_write");
                else begin
                    w = exp_wr.pop_front();
                    chk("wr_addr", addr_ext, w.addr);
                    chk("wr_data", 64'(wdata_ext), 64'(w.data));
                end
                last_wr_addr = addr_ext;
                chk("in_ready_during_write", 64'(in_ready), 64'(0));
                chk("wen_ren_exclusive", 64'(ren_ext), 64'(0));
            end
            if (ren_ext) ren_cnt++;
            if ((done | error) && !prev_fin) begin
                if (exp_res.size() == 0) fail_now("unexpected_outcome");
                else begin
                    r = exp_res.pop_front();
                    chk("done", 64'(done), 64'(r.d));
                    chk("error", 64'(error), 64'(r.e));
                    chk("cpu_enable", 64'(cpu_enable), 64'(r.d));
                    chk("word_cnt", 64'(word_cnt), 64'(r.cnt));
                end
            end
            prev_fin = done | error;
        end
    end

    // Entered and left on a negedge; the byte transfers on the posedge in between.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail_now("in_ready_timeout");
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic start_load();
        bit was_done = done;
        start   = 1'b1;
        ren_cnt = 0;
        @(negedge clk);
        start = 1'b0;
        if (was_done) begin
            chk("restart_cpu_enable_drop", 64'(cpu_enable), 64'(0));
            chk("restart_done_drop", 64'(done), 64'(0));
        end
    endtask

    task automatic wait_fin(output int lat);
        lat = 0;
        while (!(done | error) && lat < 5000) begin
            @(negedge clk);
            lat++;
        end
        if (!(done | error)) fail_now("outcome_timeout");
    endtask

    function automatic logic [31:0] xor_img(input int n);
        logic [31:0] x = 32'h0;
        for (int i = 0; i < n; i++) x ^= img[i];
        return x;
    endfunction

    // Reference model: framing rules decide writes, outcome, readback cost.
    task automatic run_image(input int n, input logic [31:0] csum, input bit gaps);
        int   lat;
        bit   match;
        bit   ok;
        logic [15:0] n16 = 16'(n);
        start_load();
        if (n == 0 || n > (1 << ADDR_W)) begin
            exp_res.push_back('{d: 1'b0, e: 1'b1, cnt: '0});
            send_byte(n16[7:0], gaps);
            send_byte(n16[15:8], gaps);
            wait_fin(lat);
            chk("bad_len_latency", 64'(lat), 64'(0));
            repeat (3) begin
                @(negedge clk);
                chk("in_ready_after_bad_len", 64'(in_ready), 64'(0));
            end
            return;
        end
        send_byte(n16[7:0], gaps);
        send_byte(n16[15:8], gaps);
        for (int i = 0; i < n; i++) begin
            logic [31:0] w = img[i];
            exp_wr.push_back('{addr: BASE + 64'(4 * i), data: w});
            for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps);
        end
        match = (csum == xor_img(n));
        ok    = match && !(VERIFY && corrupt && n > 1);
        exp_res.push_back('{d: ok, e: !ok, cnt: (ADDR_W+1)'(n)});
        for (int k = 0; k < 4; k++) send_byte(csum[8*k +: 8], gaps);
        wait_fin(lat);
        chk("final_latency", 64'(lat), 64'((VERIFY && match) ? 2 * n : 0));
        chk("ren_pulses", 64'(ren_cnt), 64'((VERIFY && match) ? n : 0));
    endtask

    initial begin
        int wen_seen;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_wen", 64'(wen_ext), 64'(0));
        chk("rst_ren", 64'(ren_ext), 64'(0));
        chk("rst_cpu_enable", 64'(cpu_enable), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_error", 64'(error), 64'(0));
        chk("rst_addr", addr_ext, BASE);
        chk("rst_wdata", 64'(wdata_ext), 64'(0));
        chk("rst_word_cnt", 64'(word_cnt), 64'(0));

        img = '{32'h0050_0093, 32'h0010_0113};
        run_image(2, 32'h0040_0180, 1'b0);   // happy path
        run_image(2, 32'h0000_0000, 1'b0);   // bad checksum, restart from DONE
        run_image(2, 32'h0040_0180, 1'b1);   // gapped valid
        run_image(0, 32'h0, 1'b0);
        run_image(513, 32'h0, 1'b0);

        img.delete();
        for (int i = 0; i < 512; i++) img.push_back($urandom);
        run_image(512, xor_img(512), 1'b1);
        chk("n512_last_addr", last_wr_addr, BASE + 64'h7FC);

        for (int t = 0; t < 6; t++) begin
            int n = $urandom_range(1, 8);
            img.delete();
            for (int i = 0; i < n; i++) img.push_back($urandom);
            run_image(n, ($urandom_range(0, 2) == 0) ? xor_img(n) ^ (32'h1 << $urandom_range(0, 31))
                                                     : xor_img(n), 1'b1);
        end

        img = '{32'h0050_0093, 32'h0010_0113};
        corrupt = 1'b1;
        run_image(2, 32'h0040_0180, 1'b0);
        corrupt = 1'b0;
        run_image(2, 32'h0040_0180, 1'b0);

        // Reset in the middle of a data word.
        start_load();
        send_byte(8'd3, 1'b0);
        send_byte(8'd0, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 64'(in_ready), 64'(0));
        chk("midrst_cpu_enable", 64'(cpu_enable), 64'(0));
        chk("midrst_done", 64'(done), 64'(0));
        chk("midrst_word_cnt", 64'(word_cnt), 64'(0));
        chk("midrst_wdata", 64'(wdata_ext), 64'(0));
        chk("midrst_addr", addr_ext, BASE);
        rst = 1'b0;
        in_valid = 1'b1;
        wen_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (wen_ext) wen_seen++;
        end
        in_valid = 1'b0;
        chk("midrst_no_wen", 64'(wen_seen), 64'(0));

        chk("pending_writes", 64'(exp_wr.size()), 64'(0));
        chk("pending_outcomes", 64'(exp_res.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
